// File: rtl/fifo_read_valid_ready_adapter.sv
// Turns a first-word-fall-through FIFO read port into a registered valid/ready stream.
// A 2-entry skid buffer sustains one transfer per cycle without an output_ready -> read_enable path.
`timescale 1ns/1ps
module fifo_read_valid_ready_adapter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic             read_enable,
  input  logic [WIDTH-1:0] read_data,
  input  logic             read_empty,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  // Pop request depends only on registered state and FIFO status, never on output_ready.
  assign read_enable  = !read_empty && (state_q != TWO) && !flush && !reset;
  assign push         = read_enable;
  assign output_valid = (state_q != EMPTY);
  assign pop          = output_valid && output_ready && !flush;
  assign output_data  = head_q;
  assign occupancy    = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = read_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            tail_d  = read_data;
          end else if (!push && pop) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_d  = read_data;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_valid_ready_adapter.sv
// Randomized bench for fifo_read_valid_ready_adapter: an emulated FWFT FIFO feeds the DUT and a
// queue model of the buffer predicts every output; delivered data is scoreboarded against pops.
`timescale 1ns/1ps
module tb_fifo_read_valid_ready_adapter;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         read_enable;
  logic [W-1:0] read_data = '0;
  logic         read_empty = 1'b1;
  logic         output_valid;
  logic         output_ready = 1'b0;
  logic [W-1:0] output_data;
  logic [1:0]   occupancy;

  realtime half_period = 5.0;
  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] src[$];       // FIFO contents upstream
  logic [W-1:0] mdl[$];       // buffered entries, oldest first
  logic [W-1:0] fifo_out[$];  // everything the DUT popped from the FIFO
  logic [W-1:0] dut_got[$];   // everything the DUT handed to the consumer

  fifo_read_valid_ready_adapter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .read_enable(read_enable), .read_data(read_data), .read_empty(read_empty),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .occupancy(occupancy)
  );

  always #(half_period) clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  // One cycle: drive at negedge, check, advance model over the posedge, return at next negedge.
  task automatic step(input bit rdy, input bit avail, input bit fl);
    logic         exp_re, dut_re;
    logic [W-1:0] rd;
    output_ready = rdy;
    flush        = fl;
    read_empty   = !(avail && src.size() > 0);
    read_data    = (src.size() > 0) ? src[0] : '0;
    #0.1;
    exp_re = !read_empty && (mdl.size() < 2) && !fl;
    vectors++;
    if (occupancy !== 2'(mdl.size())) begin
      miscompares++;
      $display("FAIL occupancy: got %0d expected %0d", occupancy, mdl.size());
    end
    vectors++;
    if (output_valid !== (mdl.size() > 0)) begin
      miscompares++;
      $display("FAIL output_valid: got %b expected %b", output_valid, mdl.size() > 0);
    end
    if (mdl.size() > 0) begin
      vectors++;
      if (output_data !== mdl[0]) begin
        miscompares++;
        $display("FAIL output_data: got %h expected %h", output_data, mdl[0]);
      end
    end
    vectors++;
    if (read_enable !== exp_re) begin
      miscompares++;
      $display("FAIL read_enable: got %b expected %b", read_enable, exp_re);
    end
    dut_re = read_enable;
    rd     = read_data;
    if (output_valid && rdy && !fl) dut_got.push_back(output_data);
    @(posedge clock);
    if (dut_re === 1'b1 && src.size() > 0) fifo_out.push_back(src.pop_front());
    if (fl) mdl.delete();
    else begin
      if (mdl.size() > 0 && rdy) void'(mdl.pop_front());
      if (exp_re) mdl.push_back(rd);
    end
    @(negedge clock);
  endtask

  task automatic clear_lists();
    mdl.delete(); fifo_out.delete(); dut_got.delete();
  endtask

  task automatic check_outputs_reset(input string tag);
    vectors++;
    if (occupancy !== 2'd0 || output_valid !== 1'b0 || output_data !== '0 || read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: occ=%0d valid=%b data=%h re=%b expected 0/0/00/0",
               tag, occupancy, output_valid, output_data, read_enable);
    end
  endtask

  task automatic test_reset();
    src = '{8'h11, 8'h22, 8'h33};
    clear_lists();
    read_empty = 1'b0; read_data = src[0]; output_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs_reset("reset_hold");
    reset = 1'b0;
    step(0, 1, 0);
    vectors++;
    if (output_valid !== 1'b1 || output_data !== 8'h11) begin
      miscompares++;
      $display("FAIL reset_first_entry: valid=%b data=%h expected 1/11", output_valid, output_data);
    end
    step(0, 1, 0);  // now holding two entries
    #0.5 reset = 1'b1;
    #0.1 check_outputs_reset("reset_mid_transfer");
    @(negedge clock);
    vectors++;
    if (src.size() !== 1) begin
      miscompares++;
      $display("FAIL reset_fifo_untouched: fifo depth %0d expected 1", src.size());
    end
    reset = 1'b0;
    src.delete();
    clear_lists();
    step(1, 1, 0);
  endtask

  task automatic test_streaming();
    logic [W-1:0] exp[4];
    clear_lists();
    for (int i = 0; i < 4; i++) begin exp[i] = W'($urandom); src.push_back(exp[i]); end
    repeat (6) step(1, 1, 0);
    vectors++;
    if (dut_got.size() !== 4) begin
      miscompares++;
      $display("FAIL stream_count: got %0d expected 4", dut_got.size());
    end
    for (int i = 0; i < 4 && i < dut_got.size(); i++) begin
      vectors++;
      if (dut_got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL stream_order[%0d]: got %h expected %h", i, dut_got[i], exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] first;
    clear_lists();
    first = W'($urandom);
    src.push_back(first);
    for (int i = 0; i < 3; i++) src.push_back(W'($urandom));
    repeat (5) step(0, 1, 0);
    read_empty = 1'b0; output_ready = 1'b0; flush = 1'b0;
    #0.1;
    vectors++;
    if (fifo_out.size() !== 2 || occupancy !== 2'd2 || output_data !== first || read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL stall: pops=%0d occ=%0d data=%h re=%b expected 2/2/%h/0",
               fifo_out.size(), occupancy, output_data, read_enable, first);
    end
  endtask

  task automatic test_toggle_ready();
    for (int i = 0; i < 3; i++) src.push_back(W'($urandom));
    for (int i = 0; i < 10; i++) step(bit'(i % 2 == 0), bit'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 12 && mdl.size() > 0; i++) step(1, 0, 0);
    vectors++;
    if (dut_got.size() !== fifo_out.size()) begin
      miscompares++;
      $display("FAIL toggle_count: delivered %0d expected %0d", dut_got.size(), fifo_out.size());
    end
    for (int i = 0; i < dut_got.size() && i < fifo_out.size(); i++) begin
      vectors++;
      if (dut_got[i] !== fifo_out[i]) begin
        miscompares++;
        $display("FAIL toggle_order[%0d]: got %h expected %h", i, dut_got[i], fifo_out[i]);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    src.delete();
    clear_lists();
    for (int i = 0; i < 4; i++) src.push_back(W'($urandom));
    step(0, 1, 0);
    step(0, 1, 0);
    n = dut_got.size();
    step(1, 1, 1);
    vectors++;
    if (occupancy !== 2'd0 || output_valid !== 1'b0 || dut_got.size() !== n) begin
      miscompares++;
      $display("FAIL flush: occ=%0d valid=%b delivered=%0d expected 0/0/%0d",
               occupancy, output_valid, dut_got.size(), n);
    end
    repeat (4) step(1, 1, 0);
  endtask

  task automatic test_random(input realtime hp);
    logic [W-1:0] sent[$];
    int cycles = 0;
    half_period = hp;
    @(negedge clock);
    src.delete();
    clear_lists();
    for (int i = 0; i < 100; i++) src.push_back(W'($urandom));
    sent = src;
    while (dut_got.size() < 100 && cycles < 4000) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
      cycles++;
    end
    vectors++;
    if (dut_got.size() !== 100) begin
      miscompares++;
      $display("FAIL random_timeout: delivered %0d expected 100 within budget", dut_got.size());
    end
    for (int i = 0; i < dut_got.size() && i < 100; i++) begin
      vectors++;
      if (dut_got[i] !== sent[i]) begin
        miscompares++;
        $display("FAIL random_order[%0d]: got %h expected %h", i, dut_got[i], sent[i]);
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_streaming();
    test_stall();
    test_toggle_ready();
    test_flush();
    test_random(5.0);
    test_random(1.59);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
